// File: rtl/uart_pkg.sv
// Shared UART types and constants: receive FSM state encoding and default framing.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_e;

    localparam int unsigned UART_OVERSAMPLE_DEFAULT = 16;
    localparam int unsigned UART_DATA_BITS_DEFAULT  = 8;
    localparam int unsigned UART_DATA_BITS_MIN      = 5;
    localparam int unsigned UART_DATA_BITS_MAX      = 8;

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for an asynchronous level input, with a selectable reset value.
module uart_sync_2ff #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receive engine: oversampled 8N1 deserialiser with a valid/ready byte output.
//
// state | meaning
// IDLE  | waiting for a high-to-low edge on the synchronised line
// START | counting to mid start bit; a high sample there is treated as a glitch
// DATA  | sampling one data bit per bit period, LSB first
// STOP  | sampling the stop bit; high loads the byte, low flags a frame error
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OverSampleRate = 16,
    parameter int unsigned DataBits       = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                baudx16_tick_i,
    input  logic                rx_i,
    input  logic                rx_ready_i,
    output logic [DataBits-1:0] rx_data_o,
    output logic                rx_valid_o,
    output logic                rx_busy_o,
    output logic                rx_frame_err_o,
    output logic                rx_overrun_o
);

    localparam int unsigned TW = $clog2(OverSampleRate);
    localparam int unsigned BW = $clog2(DataBits + 1);

    localparam logic [TW-1:0] TICK_HALF = TW'(OverSampleRate / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OverSampleRate - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DataBits - 1);

    uart_rx_state_e      state_q;
    logic [TW-1:0]       tick_cnt_q;
    logic [BW-1:0]       bit_cnt_q;
    logic [DataBits-1:0] shift_q;
    logic [DataBits-1:0] data_q;
    logic                valid_q;
    logic                busy_q;
    logic                frame_err_q;
    logic                overrun_q;
    logic                rx_prev_q;

    logic rx_s;
    logic start_edge;
    logic accept;

    uart_sync_2ff #(
        .ResetVal (1'b1)
    ) u_sync_rx (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rx_i),
        .q_o   (rx_s)
    );

    assign start_edge = rx_prev_q & ~rx_s;
    assign accept     = valid_q & rx_ready_i;

    // Frame FSM with counters, shift register and registered handshake/status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rx_prev_q   <= 1'b1;
        end else begin
            rx_prev_q   <= rx_s;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (accept) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        state_q    <= START;
                        tick_cnt_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                START: begin
                    if (baudx16_tick_i) begin
                        if (tick_cnt_q == TICK_HALF) begin
                            if (!rx_s) begin
                                state_q    <= DATA;
                                tick_cnt_q <= '0;
                                bit_cnt_q  <= '0;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TW'(1);
                        end
                    end
                end
                DATA: begin
                    if (baudx16_tick_i) begin
                        if (tick_cnt_q == TICK_LAST) begin
                            shift_q    <= {rx_s, shift_q[DataBits-1:1]};
                            tick_cnt_q <= '0;
                            bit_cnt_q  <= bit_cnt_q + BW'(1);
                            if (bit_cnt_q == BIT_LAST) begin
                                state_q <= STOP;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TW'(1);
                        end
                    end
                end
                STOP: begin
                    if (baudx16_tick_i) begin
                        if (tick_cnt_q == TICK_LAST) begin
                            state_q    <= IDLE;
                            busy_q     <= 1'b0;
                            tick_cnt_q <= '0;
                            if (rx_s) begin
                                // A load in the same cycle as an accept keeps valid set.
                                data_q    <= shift_q;
                                valid_q   <= 1'b1;
                                overrun_q <= valid_q & ~rx_ready_i;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data_o      = data_q;
    assign rx_valid_o     = valid_q;
    assign rx_busy_o      = busy_q;
    assign rx_frame_err_o = frame_err_q;
    assign rx_overrun_o   = overrun_q;

endmodule
